// File: rtl/multicycle_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the RV32I multi-cycle control path.
// Holds the sequencer state enum, the base opcode constants, the opcode
// class used inside the controller, and the select encodings for the
// immediate generator, PC mux, write-back mux and ALU op decoder.
// The datapath and immediate generator import the same definitions, so an
// encoding change here is seen by every block at once.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC    = 4'd2,
        ALU_WB  = 4'd3,
        ADDR    = 4'd4,
        MEM_RD  = 4'd5,
        LOAD_WB = 4'd6,
        MEM_WR  = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        LUI_WB  = 4'd10,
        TRAP    = 4'd11
    } state_t;

    // Instruction class, captured in DECODE. CLS_NONE doubles as the reset
    // value and the class of an unknown opcode.
    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_R      = 4'd1,
        CLS_IALU   = 4'd2,
        CLS_AUIPC  = 4'd3,
        CLS_LOAD   = 4'd4,
        CLS_STORE  = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_LUI    = 4'd9
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_OLDIMM = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_opcode_decode: purely combinational opcode classifier.
// Ports:
//   opcode   in  7  IR[6:0]
//   op_class out 4  instruction class (CLS_NONE when unknown)
//   imm_sel  out 3  immediate format for this opcode (I encoding when unknown)
//   legal    out 1  opcode is one of the supported RV32I base opcodes
module ctrl_opcode_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] imm_sel,
    output logic       legal
);

    // Map each base opcode to its class and immediate format. R-type has no
    // immediate and shares the all-zero I encoding with unknown opcodes.
    always_comb begin
        op_class = CLS_NONE;
        imm_sel  = IMM_I;
        legal    = 1'b1;
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_IALU:   op_class = CLS_IALU;
            OP_AUIPC:  begin op_class = CLS_AUIPC;  imm_sel = IMM_U; end
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  begin op_class = CLS_STORE;  imm_sel = IMM_S; end
            OP_BRANCH: begin op_class = CLS_BRANCH; imm_sel = IMM_B; end
            OP_JAL:    begin op_class = CLS_JAL;    imm_sel = IMM_J; end
            OP_JALR:   op_class = CLS_JALR;
            OP_LUI:    begin op_class = CLS_LUI;    imm_sel = IMM_U; end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   opcode              IR[6:0], looked at only in DECODE
//   branch_taken        comparator result, used only in BRANCH
//   mem_ready           memory completion, used only in FETCH/MEM_RD/MEM_WR
//   imm_sel             registered immediate format, updated leaving DECODE
//   ir_write, pc_write, pc_src             IR/PC update controls
//   mem_read, mem_write                    memory requests, held until ready
//   alu_src_a, alu_src_b, alu_op           ALU operand/op selects
//   reg_write, wb_sel                      register write-back controls
//   instr_done, illegal_instr              end-of-instruction pulses
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic [2:0] imm_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t     state, next_state;
    op_class_t  cls_q, dec_class;
    logic [2:0] imm_q, dec_imm;
    logic       dec_legal;

    ctrl_opcode_decode u_decode (
        .opcode   (opcode),
        .op_class (dec_class),
        .imm_sel  (dec_imm),
        .legal    (dec_legal)
    );

    // State register plus the per-instruction class and immediate format,
    // both captured only on the edge leaving DECODE so they stay stable for
    // the remainder of the instruction and through the next FETCH/DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cls_q <= CLS_NONE;
            imm_q <= IMM_I;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                cls_q <= dec_class;
                imm_q <= dec_imm;
            end
        end
    end

    // Reset forces the visible format to zero in the same cycle, matching
    // the rest of the outputs which are all silenced while rst is high.
    assign imm_sel = rst ? IMM_I : imm_q;

    // Next-state and Moore output decode. Only FETCH/MEM_RD/MEM_WR look at
    // mem_ready and only BRANCH looks at branch_taken, so a stray ready or
    // comparator pulse elsewhere has no effect.
    always_comb begin
        next_state    = state;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 1'b0;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        case (state)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (!dec_legal) begin
                    next_state = TRAP;
                end else begin
                    case (dec_class)
                        CLS_R, CLS_IALU, CLS_AUIPC: next_state = EXEC;
                        CLS_LOAD, CLS_STORE:        next_state = ADDR;
                        CLS_BRANCH:                 next_state = BRANCH;
                        CLS_JAL, CLS_JALR:          next_state = JUMP;
                        CLS_LUI:                    next_state = LUI_WB;
                        default:                    next_state = TRAP;
                    endcase
                end
            end
            EXEC: begin
                alu_op = ALU_FUNCT;
                if (cls_q == CLS_AUIPC) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                    alu_op    = ALU_ADD;
                end else if (cls_q == CLS_IALU) begin
                    alu_src_b = 1'b1;
                end
                next_state = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                wb_sel     = WB_ALU;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            ADDR: begin
                alu_src_b  = 1'b1;
                alu_op     = ALU_ADD;
                next_state = (cls_q == CLS_STORE) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) next_state = LOAD_WB;
            end
            LOAD_WB: begin
                reg_write  = 1'b1;
                wb_sel     = WB_LOAD;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = FETCH;
                end
            end
            BRANCH: begin
                alu_op     = ALU_CMP;
                pc_src     = PC_OLDIMM;
                pc_write   = branch_taken;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                reg_write  = 1'b1;
                wb_sel     = WB_PC4;
                pc_write   = 1'b1;
                pc_src     = (cls_q == CLS_JALR) ? PC_JALR : PC_OLDIMM;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            LUI_WB: begin
                reg_write  = 1'b1;
                wb_sel     = WB_IMM;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            TRAP: begin
                illegal_instr = 1'b1;
                next_state    = FETCH;
            end
            default: next_state = FETCH;
        endcase

        // While reset is held every control line is quiet, which also drops
        // any outstanding memory request without owing a handshake.
        if (rst) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = PC_PLUS4;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 1'b0;
            alu_op        = ALU_ADD;
            reg_write     = 1'b0;
            wb_sel        = WB_ALU;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: cycle-by-cycle scoreboard for multicycle_ctrl.
// Each instruction is expanded into a list of per-cycle inputs and expected
// output vectors that are queued, then driven and compared one cycle at a time.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic [2:0] imm_sel;
    logic       ir_write, pc_write, mem_read, mem_write;
    logic [1:0] pc_src, alu_op, wb_sel;
    logic       alu_src_a, alu_src_b, reg_write, instr_done, illegal_instr;
    logic [17:0] obs;

    int vectors     = 0;
    int miscompares = 0;
    logic [2:0] prevImm = 3'b000;

    bit          rstQ[$];
    bit          rdyQ[$];
    bit          btQ[$];
    logic [17:0] expQ[$];
    string       tagQ[$];

    localparam int K_R = 0, K_IALU = 1, K_AUIPC = 2, K_LOAD = 3, K_STORE = 4;
    localparam int K_BRANCH = 5, K_JAL = 6, K_JALR = 7, K_LUI = 8, K_ILL = 9;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .imm_sel       (imm_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr)
    );

    assign obs = {imm_sel, ir_write, pc_write, pc_src, mem_read, mem_write,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
                  instr_done, illegal_instr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the expected outputs in the same order as obs.
    function automatic logic [17:0] vec(input logic [2:0] imm, input logic irw,
                                        input logic pcw, input logic [1:0] pcs,
                                        input logic mr, input logic mw,
                                        input logic asa, input logic asb,
                                        input logic [1:0] aop, input logic rw,
                                        input logic [1:0] wbs, input logic done,
                                        input logic ill);
        return {imm, irw, pcw, pcs, mr, mw, asa, asb, aop, rw, wbs, done, ill};
    endfunction

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string tag, input logic [17:0] got,
                               input logic [17:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b (imm|irw|pcw|pcs|mr|mw|a|b|aop|rw|wb|done|ill)",
                     tag, got, exp);
        end
    endtask

    task automatic planCycle(input bit r, input bit rdy, input bit bt,
                             input logic [17:0] e, input string tag);
        rstQ.push_back(r);
        rdyQ.push_back(rdy);
        btQ.push_back(bt);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    // Drive each queued cycle on the falling edge, let the combinational
    // outputs settle, then compare before the next rising edge.
    task automatic runQueue();
        while (expQ.size() > 0) begin
            @(negedge clk);
            rst          = rstQ.pop_front();
            mem_ready    = rdyQ.pop_front();
            branch_taken = btQ.pop_front();
            #2;
            checkOutput(tagQ.pop_front(), obs, expQ.pop_front());
        end
    endtask

    task automatic planFetch(input int waits, input string name);
        for (int i = 0; i < waits; i++)
            planCycle(0, 0, rnd(), vec(prevImm, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0),
                      {name, "/fetch_wait"});
        planCycle(0, 1, rnd(), vec(prevImm, 1, 1, 2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0),
                  {name, "/fetch"});
        planCycle(0, rnd(), rnd(), vec(prevImm, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0),
                  {name, "/decode"});
    endtask

    task automatic applyStimulus(input int kind, input int fetchWaits,
                                 input int memWaits, input bit taken,
                                 input string name);
        logic [6:0] op;
        logic [2:0] imm;
        op  = 7'b1111111;
        imm = 3'b000;
        case (kind)
            K_R:      op = 7'b0110011;
            K_IALU:   op = 7'b0010011;
            K_AUIPC:  begin op = 7'b0010111; imm = 3'b100; end
            K_LOAD:   op = 7'b0000011;
            K_STORE:  begin op = 7'b0100011; imm = 3'b001; end
            K_BRANCH: begin op = 7'b1100011; imm = 3'b010; end
            K_JAL:    begin op = 7'b1101111; imm = 3'b011; end
            K_JALR:   op = 7'b1100111;
            K_LUI:    begin op = 7'b0110111; imm = 3'b100; end
            default:  op = 7'b1111111;
        endcase
        opcode = op;
        planFetch(fetchWaits, name);
        case (kind)
            K_R, K_IALU, K_AUIPC: begin
                if (kind == K_AUIPC)
                    planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0, 0),
                              {name, "/exec"});
                else
                    planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 0, kind == K_IALU, 2'b10, 0, 2'b00, 0, 0),
                              {name, "/exec"});
                planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b00, 1, 0),
                          {name, "/alu_wb"});
            end
            K_LOAD: begin
                planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0),
                          {name, "/addr"});
                for (int i = 0; i < memWaits; i++)
                    planCycle(0, 0, rnd(), vec(imm, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0),
                              {name, "/mem_rd_wait"});
                planCycle(0, 1, rnd(), vec(imm, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0),
                          {name, "/mem_rd"});
                planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 1, 0),
                          {name, "/load_wb"});
            end
            K_STORE: begin
                planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0),
                          {name, "/addr"});
                for (int i = 0; i < memWaits; i++)
                    planCycle(0, 0, rnd(), vec(imm, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0),
                              {name, "/mem_wr_wait"});
                planCycle(0, 1, rnd(), vec(imm, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 2'b00, 1, 0),
                          {name, "/mem_wr"});
            end
            K_BRANCH:
                planCycle(0, rnd(), taken, vec(imm, 0, taken, 2'b01, 0, 0, 0, 0, 2'b01, 0, 2'b00, 1, 0),
                          {name, "/branch"});
            K_JAL:
                planCycle(0, rnd(), rnd(), vec(imm, 0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 1, 2'b10, 1, 0),
                          {name, "/jump"});
            K_JALR:
                planCycle(0, rnd(), rnd(), vec(imm, 0, 1, 2'b10, 0, 0, 0, 0, 2'b00, 1, 2'b10, 1, 0),
                          {name, "/jump"});
            K_LUI:
                planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b11, 1, 0),
                          {name, "/lui_wb"});
            default:
                planCycle(0, rnd(), rnd(), vec(imm, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1),
                          {name, "/trap"});
        endcase
        runQueue();
        prevImm = imm;
    endtask

    initial begin
        rst          = 1'b1;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        opcode       = 7'b0000000;

        planCycle(1, 0, 0, 18'd0, "reset0");
        planCycle(1, 1, 1, 18'd0, "reset1");
        runQueue();

        applyStimulus(K_R,      0, 0, 0, "add");
        applyStimulus(K_STORE,  0, 0, 0, "sw");
        applyStimulus(K_LOAD,   0, 3, 0, "lw_wait3");
        applyStimulus(K_BRANCH, 0, 0, 1, "beq_taken");
        applyStimulus(K_BRANCH, 1, 0, 0, "beq_not_taken");
        applyStimulus(K_JALR,   0, 0, 0, "jalr");
        applyStimulus(K_JAL,    0, 0, 0, "jal");
        applyStimulus(K_LUI,    0, 0, 0, "lui");
        applyStimulus(K_AUIPC,  2, 0, 0, "auipc");
        applyStimulus(K_IALU,   0, 0, 0, "addi");
        applyStimulus(K_ILL,    0, 0, 0, "illegal");
        applyStimulus(K_STORE,  1, 2, 0, "sw_wait2");

        // Reset during the second MEM_WR wait cycle, with a stray ready in
        // the same cycle; the request must drop and fetch must restart.
        opcode = 7'b0100011;
        planFetch(0, "sw_rst");
        planCycle(0, 0, 0, vec(3'b001, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0), "sw_rst/addr");
        planCycle(0, 0, 0, vec(3'b001, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0), "sw_rst/mem_wr_wait1");
        planCycle(1, 1, 0, 18'd0, "sw_rst/rst_cycle");
        planCycle(0, 0, 0, vec(3'b000, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0), "sw_rst/fetch_after");
        runQueue();
        prevImm = 3'b000;

        for (int n = 0; n < 12; n++)
            applyStimulus($urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(0, 2),
                          rnd(), $sformatf("rand%0d", n));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath select: immediate format (`imm_sel`) into the immediate generator, ALU operand and op selects, PC update, register write-back, and the instruction/data memory handshake. It sits beside the datapath and observes only the IR opcode, the branch comparator result and the memory ready strobe.

## Interface
- No parameters; all encodings come from `riscv_ctrl_pkg`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  IR[6:0]; valid from the DECODE cycle onward.
- `branch_taken`  in  1  datapath comparator result; sampled only in BRANCH.
- `mem_ready`  in  1  memory completion strobe; sampled only in FETCH, MEM_RD and MEM_WR.
- `imm_sel`  out  3  immediate format: I=000, S=001, B=010, J=011, U=100.
- `ir_write`  out  1  load IR and latch old_pc.
- `pc_write`  out  1  update PC from `pc_src`.
- `pc_src`  out  2  00 PC+4, 01 old_pc+imm, 10 (rs1+imm)&~1.
- `mem_read`, `mem_write`  out  1 each  memory request, held until `mem_ready`.
- `alu_src_a`  out  1  0 rs1, 1 old_pc.
- `alu_src_b`  out  1  0 rs2, 1 imm.
- `alu_op`  out  2  00 add, 01 compare, 10 funct3/funct7 decode.
- `reg_write`  out  1  write rd.
- `wb_sel`  out  2  00 ALU result, 01 load data, 10 old_pc+4, 11 imm.
- `instr_done`  out  1  one-cycle pulse in the last cycle of a legal instruction.
- `illegal_instr`  out  1  one-cycle pulse on an unknown opcode.

## Operation
- **States (4-bit):** FETCH, DECODE, EXEC, ALU_WB, ADDR, MEM_RD, LOAD_WB, MEM_WR, BRANCH, JUMP, LUI_WB, TRAP.
- **FETCH:** `mem_read`=1.
  - While `mem_ready`=0, stay in FETCH.
  - When `mem_ready`=1 (same cycle): `ir_write`=1, `pc_write`=1, `pc_src`=00, next state DECODE.
- **DECODE:** one cycle. Register `imm_sel` from the opcode. Branch on opcode class:
  - 0110011 R and 0010011 I-ALU → EXEC.
  - 0010111 AUIPC → EXEC.
  - 0000011 LOAD → ADDR.
  - 0100011 STORE → ADDR.
  - 1100011 → BRANCH.
  - 1101111 JAL and 1100111 JALR → JUMP.
  - 0110111 LUI → LUI_WB.
  - Any other value → TRAP.
- **EXEC:** `alu_op`=10.
  - R: `alu_src_b`=0.
  - I-ALU: `alu_src_b`=1.
  - AUIPC: `alu_src_a`=1, `alu_src_b`=1, `alu_op`=00.
  - Next state ALU_WB.
- **ALU_WB:** `reg_write`=1, `wb_sel`=00, `instr_done`=1 → FETCH.
- **ADDR:** `alu_src_b`=1, `alu_op`=00. Next state MEM_RD (load) or MEM_WR (store).
- **MEM_RD:** `mem_read`=1 until `mem_ready`, then → LOAD_WB.
- **LOAD_WB:** `reg_write`=1, `wb_sel`=01, `instr_done`=1 → FETCH.
- **MEM_WR:** `mem_write`=1 until `mem_ready`. On `mem_ready`: `instr_done`=1 → FETCH.
- **BRANCH:** `alu_op`=01, `pc_src`=01, `pc_write`=`branch_taken`, `instr_done`=1 → FETCH.
- **JUMP:** `reg_write`=1, `wb_sel`=10, `pc_write`=1.
  - `pc_src`=01 for JAL, 10 for JALR.
  - `instr_done`=1 → FETCH.
- **LUI_WB:** `reg_write`=1, `wb_sel`=11, `instr_done`=1 → FETCH.
- **TRAP:** `illegal_instr`=1; no writes → FETCH.
- **`imm_sel` table (registered):**
  - I for LOAD, I-ALU and JALR.
  - S for STORE, B for BRANCH, J for JAL.
  - U for LUI and AUIPC.
  - 000 for R and illegal opcodes.
- **Output defaults:** every output not listed for a state is 0. `imm_sel` holds its registered value.

## Timing
- **Output decoding:** all outputs except `imm_sel` are Moore decodes of state plus the registered opcode class. `mem_ready` and `branch_taken` gate same-cycle outputs only in the states listed above.
- **`imm_sel` update:** `imm_sel` updates at the DECODE→next edge. It is stable from the first post-DECODE cycle until the next DECODE.
- **Minimum latency** (FETCH counted as 1, zero-wait memory):
  - BRANCH, JAL, JALR, LUI: 3 cycles.
  - R, I-ALU, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
- **Wait states:** each wait cycle on `mem_ready` adds exactly 1 cycle.
- **Reset:**
  - `rst`=1 → next cycle the state is FETCH, `imm_sel`=000 and the opcode class is cleared.
  - While `rst`=1, all outputs are 0, including `mem_read`.
  - Reset mid-access drops the request with no handshake owed.
- **Spurious ready:** `mem_ready`=1 in any other state is ignored.
- **Same-cycle events:** `mem_ready` arriving in the same cycle as `rst` → reset wins.

## Structure
- **`riscv_ctrl_pkg`** holds:
  - the state enum;
  - the opcode constants;
  - the `imm_sel`, `pc_src`, `wb_sel` and `alu_op` encodings.
  The immediate generator and the datapath import the same encodings.
- **`ctrl_opcode_decode`** is one combinational sub-module: opcode → {class, imm_sel, legal}. `multicycle_ctrl` registers its outputs in DECODE.

## Test plan
- ADD (0110011), `mem_ready`=1 in FETCH → cycle 4: `reg_write`=1, `wb_sel`=00, `instr_done`=1; cycle 5 is FETCH.
- LOAD (0000011), `mem_ready` low 3 cycles in MEM_RD → `mem_read` held 3 cycles; LOAD_WB at cycle 8 with `wb_sel`=01; `imm_sel`=000 from cycle 3.
- BRANCH (1100011):
  - `branch_taken`=1 → cycle 3: `pc_write`=1, `pc_src`=01, `imm_sel`=010.
  - `branch_taken`=0 → `pc_write`=0, `instr_done`=1.
- JALR (1100111) → cycle 3: `pc_src`=10, `wb_sel`=10, `reg_write`=1, `imm_sel`=000. JAL → `pc_src`=01, `imm_sel`=011.
- Opcode 1111111 → cycle 3: `illegal_instr`=1 with no `reg_write`/`pc_write`/`mem_*`; cycle 4 is FETCH.
- `rst` asserted in the second MEM_WR wait cycle → next cycle FETCH, `mem_write`=0, `imm_sel`=000; `mem_read` rises the cycle after `rst` falls.
